// File: rtl/output_stage.sv
// ---------------------------------------------------------------------------
// output_stage
//
// Pops one packet entry at a time from the upstream packet FIFO, checks its
// header, and serialises the left-aligned payload as DATA_W-bit words to the
// channel picked by the one-hot ch_sel field. Entries with a bad header are
// dropped and reported with a one-cycle hdr_err pulse. All outputs are
// registered.
//
// Ports:
//   clk_in          system clock
//   rst             synchronous, active-high reset
//   fifo_empty      FIFO holds no entry
//   fifo_r_enable   FIFO read strobe; entry is valid the cycle after it
//   data_from_fifo  {payload (word0 in the top bits), ch_sel, len_code}
//   data_out        current payload word
//   ch_valid        one-hot qualifier of data_out per channel
//   sop / eop       data_out is the first / last word of a packet
//   out_ready       sink accepts the word when out_ready && |ch_valid
//   hdr_err         one-cycle pulse when an entry is dropped
//   busy            high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module output_stage #(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 8,
  parameter int MAX_WORDS = 8
) (
  input  logic                               clk_in,
  input  logic                               rst,
  input  logic                               fifo_empty,
  output logic                               fifo_r_enable,
  input  logic [DATA_W*MAX_WORDS+NUM_CH+3:0] data_from_fifo,
  output logic [DATA_W-1:0]                  data_out,
  output logic [NUM_CH-1:0]                  ch_valid,
  output logic                               sop,
  output logic                               eop,
  input  logic                               out_ready,
  output logic                               hdr_err,
  output logic                               busy
);

  localparam int         PAY_W   = DATA_W * MAX_WORDS;
  localparam logic [3:0] MAX_LEN = 4'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, READ, LOAD, SEND} state_t;

  state_t              state_q, state_d;
  logic [PAY_W-1:0]    shreg_q, shreg_d;
  logic [3:0]          remaining_q, remaining_d;
  logic                fifo_r_enable_d;
  logic [DATA_W-1:0]   data_out_d;
  logic [NUM_CH-1:0]   ch_valid_d;
  logic                sop_d, eop_d, hdr_err_d, busy_d;

  logic [PAY_W-1:0]    entry_payload;
  logic [NUM_CH-1:0]   entry_ch;
  logic [3:0]          entry_len;
  logic                ch_onehot;
  logic                hdr_ok;

  assign entry_payload = data_from_fifo[PAY_W+NUM_CH+3:NUM_CH+4];
  assign entry_ch      = data_from_fifo[NUM_CH+3:4];
  assign entry_len     = data_from_fifo[3:0];

  // x & (x-1) clears the lowest set bit, so it is zero only for a single bit
  assign ch_onehot = (entry_ch != '0) && ((entry_ch & (entry_ch - NUM_CH'(1))) == '0);
  assign hdr_ok    = ch_onehot && (entry_len != 4'd0) && (entry_len <= MAX_LEN);

  // Next-state and next-output logic. Outputs hold by default so that a
  // stalled word stays stable; strobes default low so they only pulse.
  always_comb begin
    state_d         = state_q;
    shreg_d         = shreg_q;
    remaining_d     = remaining_q;
    fifo_r_enable_d = 1'b0;
    hdr_err_d       = 1'b0;
    data_out_d      = data_out;
    ch_valid_d      = ch_valid;
    sop_d           = sop;
    eop_d           = eop;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_r_enable_d = 1'b1;
          state_d         = READ;
        end
      end

      READ: begin
        state_d = LOAD;
      end

      LOAD: begin
        if (hdr_ok) begin
          shreg_d     = entry_payload;
          remaining_d = entry_len;
          data_out_d  = entry_payload[PAY_W-1 -: DATA_W];
          ch_valid_d  = entry_ch;
          sop_d       = 1'b1;
          eop_d       = (entry_len == 4'd1);
          state_d     = SEND;
        end else begin
          hdr_err_d = 1'b1;
          state_d   = IDLE;
        end
      end

      SEND: begin
        if (out_ready) begin
          if (remaining_q == 4'd1) begin
            ch_valid_d  = '0;
            sop_d       = 1'b0;
            eop_d       = 1'b0;
            remaining_d = 4'd0;
            state_d     = IDLE;
          end else begin
            // the word after the one on data_out sits just below the top slot
            shreg_d     = shreg_q << DATA_W;
            data_out_d  = shreg_q[PAY_W-DATA_W-1 -: DATA_W];
            remaining_d = remaining_q - 4'd1;
            sop_d       = 1'b0;
            eop_d       = (remaining_q == 4'd2);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any packet in flight.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      remaining_q   <= '0;
      fifo_r_enable <= 1'b0;
      data_out      <= '0;
      ch_valid      <= '0;
      sop           <= 1'b0;
      eop           <= 1'b0;
      hdr_err       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      remaining_q   <= remaining_d;
      fifo_r_enable <= fifo_r_enable_d;
      data_out      <= data_out_d;
      ch_valid      <= ch_valid_d;
      sop           <= sop_d;
      eop           <= eop_d;
      hdr_err       <= hdr_err_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_output_stage.sv
// ---------------------------------------------------------------------------
// tb_output_stage
//
// Bench for output_stage. A queue models the packet FIFO (one-cycle read
// latency). Every pushed entry is turned into expected events straight from
// the packet rules: a drop for a bad header, otherwise len_code words taken
// from the top of the payload with sop on the first and eop on the last.
// The monitor matches accepted words and hdr_err pulses against that list.
// ---------------------------------------------------------------------------
module tb_output_stage;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic         fifo_r_enable;
  logic [139:0] data_from_fifo = '0;
  logic [15:0]  data_out;
  logic [7:0]   ch_valid;
  logic         sop, eop;
  logic         out_ready = 1'b0;
  logic         hdr_err;
  logic         busy;

  output_stage dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_r_enable  (fifo_r_enable),
    .data_from_fifo (data_from_fifo),
    .data_out       (data_out),
    .ch_valid       (ch_valid),
    .sop            (sop),
    .eop            (eop),
    .out_ready      (out_ready),
    .hdr_err        (hdr_err),
    .busy           (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          is_drop;
    logic [15:0] word;
    logic [7:0]  ch;
    bit          sop;
    bit          eop;
  } ev_t;

  typedef struct {
    logic [7:0] ch;
    logic [3:0] len;
    int         exp_err;
    int         exp_words;
  } vec_t;

  logic [139:0] fifo_q[$];
  ev_t          sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobes = 0;
  int err_seen = 0;
  int words_seen = 0;
  int sop_cyc = 0;
  int eop_cyc = 0;
  int pat_idx = 0;

  bit          prev_stall = 0;
  bit          prev_hdr = 0;
  bit          in_packet = 0;
  logic [15:0] prev_data = '0;
  logic [7:0]  prev_ch = '0;
  logic        prev_sop = 0;
  logic        prev_eop = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue an entry in the FIFO and derive what the sink should see for it.
  task automatic push_entry(input logic [127:0] pl, input logic [7:0] ch, input logic [3:0] len);
    ev_t e;
    fifo_q.push_back({pl, ch, len});
    fifo_empty = 1'b0;
    if ($countones(ch) == 1 && len >= 4'd1 && len <= 4'd8) begin
      for (int i = 0; i < int'(len); i++) begin
        e.is_drop = 0;
        e.word    = pl[127 - 16*i -: 16];
        e.ch      = ch;
        e.sop     = (i == 0);
        e.eop     = (i == int'(len) - 1);
        sb.push_back(e);
      end
    end else begin
      e.is_drop = 1;
      e.word    = '0;
      e.ch      = '0;
      e.sop     = 0;
      e.eop     = 0;
      sb.push_back(e);
    end
  endtask

  task automatic push_random();
    logic [127:0] pl;
    logic [7:0]   ch;
    logic [3:0]   len;
    pl = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 9) < 7) begin
      ch  = 8'd1 << $urandom_range(0, 7);
      len = 4'($urandom_range(1, 8));
    end else begin
      ch  = 8'($urandom);
      len = 4'($urandom);
    end
    push_entry(pl, ch, len);
  endtask

  // One clock cycle: drive out_ready, watch the outputs at the falling edge,
  // then let the FIFO model answer a read strobe just after the rising edge.
  task automatic applyStimulus(input bit rdy);
    bit   rst_now, pop_now, have;
    ev_t  e;
    @(negedge clk_in);
    out_ready = rdy;
    rst_now   = rst;
    if (!rst_now) begin
      if (prev_stall) begin
        checkOutput("stall_data", 32'(data_out), 32'(prev_data));
        checkOutput("stall_ch", 32'(ch_valid), 32'(prev_ch));
        checkOutput("stall_sop", 32'(sop), 32'(prev_sop));
        checkOutput("stall_eop", 32'(eop), 32'(prev_eop));
      end
      if (hdr_err) begin
        err_seen++;
        checkOutput("hdr_err_one_cycle", 32'(prev_hdr), 32'd0);
        checkOutput("hdr_err_no_ch", 32'(ch_valid), 32'd0);
        have = (sb.size() > 0) ? sb[0].is_drop : 1'b0;
        checkOutput("hdr_err_expected", 32'(have), 32'd1);
        if (have) void'(sb.pop_front());
      end
      if (ch_valid != 8'd0) in_packet = 1;
      if (fifo_r_enable) checkOutput("no_read_ahead", 32'(in_packet), 32'd0);
      if ((ch_valid != 8'd0) && rdy) begin
        words_seen++;
        have = (sb.size() > 0) ? !sb[0].is_drop : 1'b0;
        checkOutput("word_expected", 32'(have), 32'd1);
        if (have) begin
          e = sb.pop_front();
          checkOutput("data_out", 32'(data_out), 32'(e.word));
          checkOutput("ch_valid", 32'(ch_valid), 32'(e.ch));
          checkOutput("sop", 32'(sop), 32'(e.sop));
          checkOutput("eop", 32'(eop), 32'(e.eop));
          if (e.sop) sop_cyc = cyc;
          if (e.eop) eop_cyc = cyc;
        end
        if (eop) in_packet = 0;
      end
      prev_stall = (ch_valid != 8'd0) && !rdy;
      prev_hdr   = hdr_err;
    end else begin
      prev_stall = 0;
      prev_hdr   = 0;
      in_packet  = 0;
    end
    prev_data = data_out;
    prev_ch   = ch_valid;
    prev_sop  = sop;
    prev_eop  = eop;
    pop_now   = fifo_r_enable && !rst_now;
    @(posedge clk_in);
    #1;
    cyc++;
    if (pop_now) begin
      strobes++;
      checkOutput("strobe_with_entry", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) data_from_fifo = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  endtask

  // mode 0: always ready, 1: random, 2: ready 1,0,0 repeating
  task automatic next_ready(input int mode, output bit r);
    case (mode)
      0:       r = 1;
      1:       r = ($urandom_range(0, 9) < 7);
      default: begin
        r = (pat_idx % 3 == 0);
        pat_idx++;
      end
    endcase
  endtask

  task automatic drain(input int mode, input int budget);
    bit done, r;
    done = 0;
    for (int n = 0; n < budget; n++) begin
      if (sb.size() == 0 && fifo_q.size() == 0 && !busy && !fifo_r_enable) begin
        done = 1;
        break;
      end
      next_ready(mode, r);
      applyStimulus(r);
    end
    checkOutput("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   s0, found, pushed;

    vecs[0] = '{8'h04, 4'd1, 0, 1};
    vecs[1] = '{8'h80, 4'd8, 0, 8};
    vecs[2] = '{8'h03, 4'd2, 1, 0};
    vecs[3] = '{8'h00, 4'd3, 1, 0};
    vecs[4] = '{8'h10, 4'd0, 1, 0};
    vecs[5] = '{8'h10, 4'd9, 1, 0};
    vecs[6] = '{8'h01, 4'd15, 1, 0};
    vecs[7] = '{8'h20, 4'd5, 0, 5};
    vecs[8] = '{8'hFF, 4'd4, 1, 0};

    // reset state
    rst = 1;
    applyStimulus(0);
    applyStimulus(0);
    rst = 0;
    checkOutput("rst_r_enable", 32'(fifo_r_enable), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_ch_valid", 32'(ch_valid), 32'd0);
    checkOutput("rst_sop", 32'(sop), 32'd0);
    checkOutput("rst_eop", 32'(eop), 32'd0);
    checkOutput("rst_hdr_err", 32'(hdr_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // single-word packet: strobe, read latency, then the word
    s0 = strobes;
    push_entry({16'hA5A5, 112'd0}, 8'h04, 4'd1);
    applyStimulus(1);
    checkOutput("t1_strobe", 32'(fifo_r_enable), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    applyStimulus(1);
    checkOutput("t1_strobe_drop", 32'(fifo_r_enable), 32'd0);
    checkOutput("t1_no_ch_yet", 32'(ch_valid), 32'd0);
    applyStimulus(1);
    checkOutput("t1_data", 32'(data_out), 32'hA5A5);
    checkOutput("t1_ch", 32'(ch_valid), 32'h04);
    checkOutput("t1_sop", 32'(sop), 32'd1);
    checkOutput("t1_eop", 32'(eop), 32'd1);
    applyStimulus(1);
    checkOutput("t1_ch_clear", 32'(ch_valid), 32'd0);
    checkOutput("t1_busy_drop", 32'(busy), 32'd0);
    applyStimulus(1);
    applyStimulus(1);
    checkOutput("t1_single_strobe", 32'(strobes - s0), 32'd1);

    // 8 words back to back with the sink always ready
    push_entry(128'h0001_0002_0003_0004_0005_0006_0007_0008, 8'h80, 4'd8);
    drain(0, 60);
    checkOutput("t2_consecutive", 32'(eop_cyc - sop_cyc), 32'd7);

    // same packet with a stalling sink
    pat_idx = 0;
    push_entry(128'h0001_0002_0003_0004_0005_0006_0007_0008, 8'h80, 4'd8);
    drain(2, 120);

    // header table, one entry at a time
    foreach (vecs[i]) begin
      err_seen   = 0;
      words_seen = 0;
      push_entry({$urandom, $urandom, $urandom, $urandom}, vecs[i].ch, vecs[i].len);
      drain(0, 60);
      checkOutput("vec_hdr_err", 32'(err_seen), 32'(vecs[i].exp_err));
      checkOutput("vec_words", 32'(words_seen), 32'(vecs[i].exp_words));
    end

    // malformed entries queued ahead of a good one
    err_seen   = 0;
    words_seen = 0;
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h03, 4'd2);
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h04, 4'd0);
    push_entry({$urandom, $urandom, $urandom, $urandom}, 8'h04, 4'd9);
    push_entry({16'hBEEF, 16'hCAFE, 16'hF00D, 80'd0}, 8'h08, 4'd3);
    drain(1, 150);
    checkOutput("queued_hdr_err", 32'(err_seen), 32'd3);
    checkOutput("queued_words", 32'(words_seen), 32'd3);

    // reset while word 3 of a 5-word packet is on the output
    push_entry({16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 48'hDEAD_BEEF_1234}, 8'h02, 4'd5);
    found = 0;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1);
      if (ch_valid != 8'd0 && data_out == 16'h0103) begin
        found = 1;
        break;
      end
    end
    checkOutput("t5_word3_reached", 32'(found), 32'd1);
    rst = 1;
    applyStimulus(0);
    rst = 0;
    checkOutput("t5_data_out", 32'(data_out), 32'd0);
    checkOutput("t5_ch_valid", 32'(ch_valid), 32'd0);
    checkOutput("t5_sop", 32'(sop), 32'd0);
    checkOutput("t5_eop", 32'(eop), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_r_enable", 32'(fifo_r_enable), 32'd0);
    sb.delete();
    push_entry({16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 64'd0}, 8'h40, 4'd4);
    drain(0, 60);

    // two back-to-back entries; no new strobe until the first eop is taken
    s0 = strobes;
    push_entry({16'h1111, 16'h2222, 96'd0}, 8'h01, 4'd2);
    push_entry({16'h3333, 16'h4444, 16'h5555, 80'd0}, 8'h10, 4'd3);
    drain(0, 60);
    checkOutput("t6_strobes", 32'(strobes - s0), 32'd2);

    // random traffic against the event model
    pushed = 0;
    for (int n = 0; n < 600 && pushed < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        push_random();
        pushed++;
      end
      applyStimulus($urandom_range(0, 9) < 7);
    end
    drain(1, 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
